// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDiv   = 2'd1,
    StDrain = 2'd2
  } fsm_e;

  localparam int unsigned DivCyclesDef = 33;
  localparam int unsigned CntWDef      = 6;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / segment control bundle between the pipeline and the hazard sequencer.
interface pipe_hazard_ctrl_if;

  logic exc_flush;
  logic if_wait;
  logic mem_wait;
  logic id_load_use;
  logic ex_div_start;

  logic pc_stall;
  logic if_id_stall;
  logic if_id_refresh;
  logic id_ex_stall;
  logic id_ex_refresh;
  logic ex_mem_stall;
  logic ex_mem_refresh;
  logic mem_wb_stall;
  logic mem_wb_refresh;
  logic div_busy;
  logic div_cancel;

  // Pipeline side: raises hazard requests, obeys segment controls.
  modport master (
    output exc_flush, if_wait, mem_wait, id_load_use, ex_div_start,
    input  pc_stall, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh,
    input  ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh,
    input  div_busy, div_cancel
  );

  // Sequencer side.
  modport slave (
    input  exc_flush, if_wait, mem_wait, id_load_use, ex_div_start,
    output pc_stall, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh,
    output ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh,
    output div_busy, div_cancel
  );

endinterface

// File: rtl/pipe_hazard_ctrl_div_busy_cnt.sv
// Divider occupancy counter and sequencer state (RUN / DIV / DRAIN).
module div_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DivCyclesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic clk,
  input  logic resetn,
  input  logic exc_flush,
  input  logic mem_wait,
  input  logic if_wait,
  input  logic ex_div_start,
  output fsm_e fsm
);

  fsm_e             fsm_q;
  logic [CNT_W-1:0] div_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q     <= StRun;
      div_cnt_q <= '0;
    end else if (exc_flush) begin
      // Flush during an outstanding fetch must discard the wrong-path return.
      fsm_q     <= if_wait ? StDrain : StRun;
      div_cnt_q <= '0;
    end else if (!mem_wait) begin
      case (fsm_q)
        StRun: begin
          if (ex_div_start) begin
            fsm_q     <= StDiv;
            div_cnt_q <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        StDiv: begin
          if (div_cnt_q == CNT_W'(1)) begin
            fsm_q     <= StRun;
            div_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q - CNT_W'(1);
          end
        end
        StDrain: begin
          if (!if_wait) fsm_q <= StRun;
        end
        default: begin
          fsm_q     <= StRun;
          div_cnt_q <= '0;
        end
      endcase
    end
  end

  assign fsm = fsm_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DivCyclesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic                clk,
  input  logic                resetn,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_cnt
`endif
);

  fsm_e fsm;

  div_busy_cnt #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_busy_cnt (
    .clk          (clk),
    .resetn       (resetn),
    .exc_flush    (hz.exc_flush),
    .mem_wait     (hz.mem_wait),
    .if_wait      (hz.if_wait),
    .ex_div_start (hz.ex_div_start),
    .fsm          (fsm)
  );

  logic pc_stall;
  logic if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic div_cancel;

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    ex_mem_stall   = 1'b0;
    mem_wb_stall   = 1'b0;
    if_id_refresh  = 1'b0;
    id_ex_refresh  = 1'b0;
    ex_mem_refresh = 1'b0;
    mem_wb_refresh = 1'b0;
    div_cancel     = 1'b0;

    if (!resetn) begin
      if_id_refresh  = 1'b1;
      id_ex_refresh  = 1'b1;
      ex_mem_refresh = 1'b1;
      mem_wb_refresh = 1'b1;
    end else begin
      if (hz.exc_flush) begin
        if_id_refresh  = 1'b1;
        id_ex_refresh  = 1'b1;
        ex_mem_refresh = 1'b1;
        mem_wb_refresh = 1'b1;
        div_cancel     = (fsm == StDiv);
      end else if (hz.mem_wait) begin
        pc_stall       = 1'b1;
        if_id_stall    = 1'b1;
        id_ex_stall    = 1'b1;
        ex_mem_stall   = 1'b1;
        mem_wb_refresh = 1'b1;
      end else if ((fsm == StDiv) || hz.ex_div_start) begin
        pc_stall       = 1'b1;
        if_id_stall    = 1'b1;
        id_ex_stall    = 1'b1;
        ex_mem_refresh = 1'b1;
      end else if (hz.id_load_use) begin
        pc_stall       = 1'b1;
        if_id_stall    = 1'b1;
        id_ex_refresh  = 1'b1;
      end else if (hz.if_wait) begin
        pc_stall       = 1'b1;
        if_id_refresh  = 1'b1;
      end

      // Every fetch landing while draining is wrong-path and must be dropped.
      if ((fsm == StDrain) && !hz.exc_flush) begin
        if_id_refresh = 1'b1;
        if (hz.if_wait) pc_stall = 1'b1;
      end
    end

    // Clearing a segment takes precedence over holding it.
    if (if_id_refresh)  if_id_stall  = 1'b0;
    if (id_ex_refresh)  id_ex_stall  = 1'b0;
    if (ex_mem_refresh) ex_mem_stall = 1'b0;
    if (mem_wb_refresh) mem_wb_stall = 1'b0;
  end

  assign hz.pc_stall       = pc_stall;
  assign hz.if_id_stall    = if_id_stall;
  assign hz.if_id_refresh  = if_id_refresh;
  assign hz.id_ex_stall    = id_ex_stall;
  assign hz.id_ex_refresh  = id_ex_refresh;
  assign hz.ex_mem_stall   = ex_mem_stall;
  assign hz.ex_mem_refresh = ex_mem_refresh;
  assign hz.mem_wb_stall   = mem_wb_stall;
  assign hz.mem_wb_refresh = mem_wb_refresh;
  assign hz.div_busy       = (fsm == StDiv);
  assign hz.div_cancel     = div_cancel;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall)     perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.exc_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule
